// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with an enable prescaler, wrap or saturate
// behaviour at the count boundaries, a one-cycle terminal-count pulse
// and a sticky boundary flag.
//
// The count runs over 0..MODULUS-1. Every limit test is made against
// MODULUS-1, held as a WIDTH-bit constant. MODULUS itself is never
// formed at WIDTH bits, so MODULUS = 2**WIDTH works without overflow.
module updown_mod_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             inc,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The prescaler needs at least one bit, even when it never advances.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] loadClamped;
  logic             stepNow;
  logic             atTop;
  logic             atBottom;
  logic             boundaryHit;

  // A load value beyond the last legal state becomes the last legal state.
  always_comb begin
    loadClamped = load_val;
    if (load_val > MAX_COUNT) begin
      loadClamped = MAX_COUNT;
    end
  end

  // A step happens on the enabled cycle that closes a prescale period.
  // dir and sat_mode only matter on this edge.
  always_comb begin
    stepNow     = inc && (presc_q == PRE_LAST);
    atTop       = (count_q == MAX_COUNT);
    atBottom    = (count_q == '0);
    boundaryHit = stepNow && (dir ? atTop : atBottom);
  end

  // Next-state selection with priority clear > load > inc.
  // tc drops on every edge that does not hit a boundary.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (clear) begin
      count_d = '0;
      presc_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = loadClamped;
      presc_d = '0;
    end else if (inc) begin
      if (stepNow) begin
        presc_d = '0;
        if (boundaryHit) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!sat_mode) begin
            count_d = dir ? '0 : MAX_COUNT;
          end
        end else if (dir) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers. Reset is asynchronous and drops any partial prescale.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      count_q <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter. Three instances share one input stream:
//   A: WIDTH=4, MODULUS=10, PRESCALE=1
//   B: WIDTH=4, MODULUS=10, PRESCALE=3
//   C: WIDTH=4, MODULUS=16, PRESCALE=1
// Expected values come from an integer reference model. They are queued
// when stimulus is issued, and a separate monitor pops and compares them
// after each rising edge.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       async_reset;
  logic       inc, dir, sat_mode, clear, load;
  logic [3:0] load_val;

  logic [3:0] countA, countB, countC;
  logic       tcA, tcB, tcC;
  logic       ovfA, ovfB, ovfC;

  typedef struct {
    int count;
    bit tc;
    bit ovf;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];

  int modTab[3] = '{10, 10, 16};
  int preTab[3] = '{1, 3, 1};
  int mCount[3];
  int mPre[3];
  bit mTc[3];
  bit mOvf[3];

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running clock: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutA (
    .clk(clk), .async_reset(async_reset), .inc(inc), .dir(dir),
    .sat_mode(sat_mode), .clear(clear), .load(load), .load_val(load_val),
    .count(countA), .tc(tcA), .ovf(ovfA)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dutB (
    .clk(clk), .async_reset(async_reset), .inc(inc), .dir(dir),
    .sat_mode(sat_mode), .clear(clear), .load(load), .load_val(load_val),
    .count(countB), .tc(tcB), .ovf(ovfB)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dutC (
    .clk(clk), .async_reset(async_reset), .inc(inc), .dir(dir),
    .sat_mode(sat_mode), .clear(clear), .load(load), .load_val(load_val),
    .count(countC), .tc(tcC), .ovf(ovfC)
  );

  // One comparison. Four-state inequality, so X or Z on an output fails.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour for one instance over one rising edge, in plain
  // integer arithmetic: leaving 0..mod-1 is a boundary event.
  task automatic modelStep(input int k, input bit clr, input bit ld, input int lv,
                           input bit en, input bit dr, input bit sat);
    int nxt;
    mTc[k] = 1'b0;
    if (clr) begin
      mCount[k] = 0;
      mPre[k]   = 0;
      mOvf[k]   = 1'b0;
    end else if (ld) begin
      mCount[k] = (lv < modTab[k]) ? lv : modTab[k] - 1;
      mPre[k]   = 0;
    end else if (en) begin
      mPre[k]++;
      if (mPre[k] == preTab[k]) begin
        mPre[k] = 0;
        nxt = dr ? mCount[k] + 1 : mCount[k] - 1;
        if (nxt < 0 || nxt >= modTab[k]) begin
          mTc[k]  = 1'b1;
          mOvf[k] = 1'b1;
          nxt     = sat ? mCount[k] : (nxt + modTab[k]) % modTab[k];
        end
        mCount[k] = nxt;
      end
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 3; k++) begin
      mCount[k] = 0;
      mPre[k]   = 0;
      mTc[k]    = 1'b0;
      mOvf[k]   = 1'b0;
    end
  endtask

  // Drive one cycle's inputs on the falling edge.
  // Queue what each instance must show after the next rising edge.
  task automatic applyStimulus(input bit clr, input bit ld, input int lv,
                               input bit en, input bit dr, input bit sat);
    @(negedge clk);
    clear    = clr;
    load     = ld;
    load_val = 4'(lv);
    inc      = en;
    dir      = dr;
    sat_mode = sat;
    for (int k = 0; k < 3; k++) begin
      modelStep(k, clr, ld, lv, en, dr, sat);
    end
    qA.push_back('{mCount[0], mTc[0], mOvf[0]});
    qB.push_back('{mCount[1], mTc[1], mOvf[1]});
    qC.push_back('{mCount[2], mTc[2], mOvf[2]});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " countA"}, 32'(countA), 0);
    checkOutput({tag, " tcA"},    32'(tcA),    0);
    checkOutput({tag, " ovfA"},   32'(ovfA),   0);
    checkOutput({tag, " countB"}, 32'(countB), 0);
    checkOutput({tag, " tcB"},    32'(tcB),    0);
    checkOutput({tag, " ovfB"},   32'(ovfB),   0);
    checkOutput({tag, " countC"}, 32'(countC), 0);
    checkOutput({tag, " tcC"},    32'(tcC),    0);
    checkOutput({tag, " ovfC"},   32'(ovfC),   0);
  endtask

  // Pulse reset between two edges, after the monitor has sampled.
  // The outputs must clear before any further clock edge.
  task automatic pulseReset();
    @(posedge clk);
    #2;
    inc         = 1'b0;
    clear       = 1'b0;
    load        = 1'b0;
    async_reset = 1'b0;
    #1;
    checkAllZero("asyncReset");
    #1;
    async_reset = 1'b1;
    resetModel();
  endtask

  // Monitor: after every rising edge, pop each expectation and compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput("countA", 32'(countA), 32'(e.count));
        checkOutput("tcA",    32'(tcA),    32'(e.tc));
        checkOutput("ovfA",   32'(ovfA),   32'(e.ovf));
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput("countB", 32'(countB), 32'(e.count));
        checkOutput("tcB",    32'(tcB),    32'(e.tc));
        checkOutput("ovfB",   32'(ovfB),   32'(e.ovf));
      end
      if (qC.size() > 0) begin
        e = qC.pop_front();
        checkOutput("countC", 32'(countC), 32'(e.count));
        checkOutput("tcC",    32'(tcC),    32'(e.tc));
        checkOutput("ovfC",   32'(ovfC),   32'(e.ovf));
      end
    end
  end

  // Directed scenarios first, then a randomized stream.
  initial begin
    bit rDir, rSat;
    int r;

    async_reset = 1'b0;
    inc         = 1'b0;
    dir         = 1'b0;
    sat_mode    = 1'b0;
    clear       = 1'b0;
    load        = 1'b0;
    load_val    = 4'd0;
    resetModel();
    #1;
    checkAllZero("powerOnReset");
    repeat (2) @(negedge clk);
    async_reset = 1'b1;

    // Wrap up from 0 for 12 cycles
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (12) applyStimulus(0, 0, 0, 1, 1, 0);

    // Saturating count down from 2
    applyStimulus(0, 1, 2, 0, 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 1, 0, 1);

    // Load clamp with inc held, then clear beats load
    applyStimulus(0, 1, 13, 1, 1, 0);
    applyStimulus(1, 1, 5, 1, 1, 0);

    // Prescale spacing, with gaps in inc
    repeat (9) applyStimulus(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, (i % 3) != 1, 1, 0);
    end

    // Asynchronous reset partway through a prescale period
    applyStimulus(0, 1, 7, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    pulseReset();
    repeat (4) applyStimulus(0, 0, 0, 1, 1, 0);

    // Top of the full-range instance wraps to zero
    applyStimulus(0, 1, 15, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 1, 1, 0);

    // Saturating at the top; tc repeats on each attempted step
    applyStimulus(0, 1, 15, 0, 1, 1);
    repeat (4) applyStimulus(0, 0, 0, 1, 1, 1);

    // Randomized stream. dir and sat_mode change occasionally.
    rDir = 1'b1;
    rSat = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15) rDir = ~rDir;
      if ($urandom_range(0, 99) < 5)  rSat = ~rSat;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        pulseReset();
      end else if (r < 6) begin
        applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 1), rDir, rSat);
      end else if (r < 18) begin
        applyStimulus(0, 1, $urandom_range(0, 15), $urandom_range(0, 1), rDir, rSat);
      end else begin
        applyStimulus(0, 0, $urandom_range(0, 15), $urandom_range(0, 9) < 8, rDir, rSat);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrain", 32'(qA.size() + qB.size() + qC.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
